// File: rtl/serial_rx_sr_ctrl.sv
// serial_rx_sr_ctrl
//   Receive side of the serial link. Recovers one frame at a time from an
//   idle-high line: start (0), NUM_BITS data bits, optional even-parity bit,
//   stop (1). A bit-period timer places the samples at mid-bit and a
//   serial-to-parallel shift register collects the data bits. The word is
//   handed to the consumer with a ready/read handshake plus error flags.
//
//   Optional feature macro: SERIAL_RX_PARITY_EN (adds the PARITY state and a
//   live parity_error flag; without it parity_error is tied 0).
//
// Parameters
//   NUM_BITS     data bits per frame, 2..16
//   SHIFT_MSB    1: first data bit ends up in rx_data[NUM_BITS-1]
//                0: first data bit ends up in rx_data[0]
//   CLKS_PER_BIT clock cycles per serial bit, even, >= 4
//
// Ports
//   clk            system clock, rising edge
//   n_rst          asynchronous active-low reset
//   serial_in      raw serial line, idle high, asynchronous to clk
//   data_read      consumer pulse: rx_data has been taken
//   rx_data        last good received word
//   data_ready     rx_data holds an unread word
//   framing_error  last frame had a 0 stop bit
//   overrun_error  an unread word was overwritten
//   parity_error   parity mismatch on the last frame

module serial_rx_sr_ctrl #(
  parameter int NUM_BITS     = 8,
  parameter int SHIFT_MSB    = 1,
  parameter int CLKS_PER_BIT = 10
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                serial_in,
  input  logic                data_read,
  output logic [NUM_BITS-1:0] rx_data,
  output logic                data_ready,
  output logic                framing_error,
  output logic                overrun_error,
  output logic                parity_error
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(NUM_BITS);

  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(NUM_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef SERIAL_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    LOAD
  } state_t;

  state_t state, state_nxt;

  // ---------------------------------------------------------------------
  // Two-flop synchronizer plus one history flop for the start-edge detect.
  // All reset to 1 so a reset never looks like a falling edge.
  // ---------------------------------------------------------------------
  logic sync1, s_in, s_prev, fall;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync1  <= 1'b1;
      s_in   <= 1'b1;
      s_prev <= 1'b1;
    end else begin
      sync1  <= serial_in;
      s_in   <= sync1;
      s_prev <= s_in;
    end
  end

  // Requiring prev = 1 means a line stuck low after a bad stop bit cannot
  // retrigger; it has to go high and fall again.
  assign fall = s_prev & ~s_in;

  // ---------------------------------------------------------------------
  // Bit-period timer and data-bit counter
  // ---------------------------------------------------------------------
  logic [CW-1:0] cnt;
  logic [BW-1:0] bit_cnt;
  logic          bit_tick, tmr_clr;

  assign bit_tick = (cnt == BIT_END);
  // Every state entry restarts the bit period.
  assign tmr_clr  = (state_nxt != state);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)                   cnt <= '0;
    else if (tmr_clr || bit_tick) cnt <= '0;
    else                          cnt <= cnt + CW'(1);
  end

  logic shift_en, load, set_fe, clr_err;
`ifdef SERIAL_RX_PARITY_EN
  logic par_en;
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)             bit_cnt <= '0;
    else if (state != DATA) bit_cnt <= '0;
    else if (shift_en)      bit_cnt <= bit_cnt + BW'(1);
  end

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    shift_en  = 1'b0;
    load      = 1'b0;
    set_fe    = 1'b0;
    clr_err   = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
    par_en    = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (fall) begin
          state_nxt = START;
          clr_err   = 1'b1;
        end
      end
      START: begin
        // Mid start bit: a high line here was a glitch, drop it silently.
        if (cnt == HALF_END) state_nxt = s_in ? IDLE : DATA;
      end
      DATA: begin
        if (bit_tick) begin
          shift_en = 1'b1;
          if (bit_cnt == LAST_BIT) begin
`ifdef SERIAL_RX_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = STOP;
`endif
          end
        end
      end
`ifdef SERIAL_RX_PARITY_EN
      PARITY: begin
        if (bit_tick) begin
          par_en    = 1'b1;
          state_nxt = STOP;
        end
      end
`endif
      STOP: begin
        if (bit_tick) begin
          if (s_in) begin
            state_nxt = LOAD;
          end else begin
            set_fe    = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      LOAD: begin
        load      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Serial-to-parallel shift register
  // ---------------------------------------------------------------------
  logic [NUM_BITS-1:0] sr, sr_shifted;

  generate
    if (SHIFT_MSB != 0) begin : g_msb_first
      assign sr_shifted = {sr[NUM_BITS-2:0], s_in};
    end else begin : g_lsb_first
      assign sr_shifted = {s_in, sr[NUM_BITS-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)        sr <= '1;
    else if (shift_en) sr <= sr_shifted;
  end

  // ---------------------------------------------------------------------
  // Consumer-facing word and flags
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rx_data       <= '1;
      data_ready    <= 1'b0;
      framing_error <= 1'b0;
      overrun_error <= 1'b0;
    end else begin
      if (clr_err)     framing_error <= 1'b0;
      else if (set_fe) framing_error <= 1'b1;

      if (data_read) begin
        data_ready    <= 1'b0;
        overrun_error <= 1'b0;
      end
      // LOAD is last so it wins over a coincident read; the read still
      // counts as having taken the old word, so no overrun then.
      if (load) begin
        rx_data    <= sr;
        data_ready <= 1'b1;
        if (data_ready && !data_read) overrun_error <= 1'b1;
      end
    end
  end

`ifdef SERIAL_RX_PARITY_EN
  logic par_err;

  // Even parity: data plus parity bit must XOR to 0. The flag persists
  // until the next start edge so a flagged word is still delivered.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)       par_err <= 1'b0;
    else if (clr_err) par_err <= 1'b0;
    else if (par_en)  par_err <= ^{sr, s_in};
  end

  assign parity_error = par_err;
`else
  assign parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_serial_rx_sr_ctrl.sv
// Bench for serial_rx_sr_ctrl. Two instances share the serial line: one
// MSB-first (SHIFT_MSB=1) and one LSB-first (SHIFT_MSB=0), so every frame
// also checks that the second instance holds the bit-reversed word.
// Frames are driven MSB-first in time (bit 7 first).
module tb_serial_rx_sr_ctrl;

  localparam int NB = 8;
  localparam int C  = 10;
`ifdef SERIAL_RX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  // Falling edge to data_ready, counted from the first clock that sees it.
  localparam int LAT  = 2 + C/2 + (NB + 1 + PB)*C + 1;
  // Stop-bit cycle index whose following edge is the LOAD cycle's edge.
  localparam int RD_J = 3 + C/2;

  logic          clk = 1'b0;
  logic          n_rst, serial_in, data_read;
  logic [NB-1:0] rx_m, rx_l;
  logic          rdy_m, fe_m, oe_m, pe_m;
  logic          rdy_l, fe_l, oe_l, pe_l;

  serial_rx_sr_ctrl #(.NUM_BITS(NB), .SHIFT_MSB(1), .CLKS_PER_BIT(C)) dut_m (
    .clk(clk), .n_rst(n_rst), .serial_in(serial_in), .data_read(data_read),
    .rx_data(rx_m), .data_ready(rdy_m), .framing_error(fe_m),
    .overrun_error(oe_m), .parity_error(pe_m));

  serial_rx_sr_ctrl #(.NUM_BITS(NB), .SHIFT_MSB(0), .CLKS_PER_BIT(C)) dut_l (
    .clk(clk), .n_rst(n_rst), .serial_in(serial_in), .data_read(data_read),
    .rx_data(rx_l), .data_ready(rdy_l), .framing_error(fe_l),
    .overrun_error(oe_l), .parity_error(pe_l));

  always #5 clk = ~clk;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   rise_cyc = 0;
  int   fall_cyc = 0;
  logic rdy_d = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    rdy_d <= rdy_m;
    if (rdy_m && !rdy_d) rise_cyc <= cyc;
  end

  function automatic logic [NB-1:0] bitrev(input logic [NB-1:0] d);
    logic [NB-1:0] r;
    for (int i = 0; i < NB; i++) r[i] = d[NB-1-i];
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [NB-1:0] d, input logic r,
                           input logic fe, input logic oe, input logic pe);
    chk({tag, " rx_data"},       rx_m, d);
    chk({tag, " data_ready"},    rdy_m, r);
    chk({tag, " framing_error"}, fe_m, fe);
    chk({tag, " overrun_error"}, oe_m, oe);
    chk({tag, " parity_error"},  pe_m, pe);
    chk({tag, " lsb rx_data"},   rx_l, bitrev(d));
    chk({tag, " lsb flags"},     {rdy_l, fe_l, oe_l, pe_l}, {r, fe, oe, pe});
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic v);
    serial_in = v;
    repeat (C) @(negedge clk);
  endtask

  task automatic pulse_read();
    @(negedge clk);
    data_read = 1'b1;
    @(negedge clk);
    data_read = 1'b0;
  endtask

  // Called at a negedge. rd_at_load raises data_read for exactly the LOAD cycle.
  task automatic send_frame(input logic [NB-1:0] w, input logic stop, input logic par,
                            input logic rd_at_load);
    fall_cyc = cyc;
    drive_bit(1'b0);
    for (int i = NB-1; i >= 0; i--) drive_bit(w[i]);
    if (PB != 0) drive_bit(par);
    serial_in = stop;
    for (int j = 0; j < C; j++) begin
      data_read = rd_at_load && (j == RD_J);
      @(negedge clk);
    end
    data_read = 1'b0;
    serial_in = 1'b1;
  endtask

  typedef struct {
    logic [NB-1:0] word;
    logic          stop;
    logic          rd_after;
    logic [NB-1:0] exp_data;
    logic          exp_rdy;
    logic          exp_fe;
    logic          exp_oe;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0};  // good frame
    vecs[1] = '{8'h3C, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b0};  // bad stop
    vecs[2] = '{8'h11, 1'b1, 1'b1, 8'h11, 1'b1, 1'b0, 1'b0};  // fe cleared
    vecs[3] = '{8'h12, 1'b1, 1'b0, 8'h12, 1'b1, 1'b0, 1'b0};  // left unread
    vecs[4] = '{8'h34, 1'b1, 1'b1, 8'h34, 1'b1, 1'b0, 1'b1};  // overrun
    vecs[5] = '{8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};  // all zeros

    n_rst     = 1'b0;
    serial_in = 1'b1;
    data_read = 1'b0;
    idle(3);
    check_all("reset", 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
    n_rst = 1'b1;
    idle(5);
    check_all("post_reset", 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 6; i++) begin
      send_frame(vecs[i].word, vecs[i].stop, ^vecs[i].word, 1'b0);
      idle(3);
      check_all($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_rdy,
                vecs[i].exp_fe, vecs[i].exp_oe, 1'b0);
      if (vecs[i].rd_after) begin
        pulse_read();
        check_all($sformatf("vec%0d_read", i), vecs[i].exp_data, 1'b0,
                  vecs[i].exp_fe, 1'b0, 1'b0);
      end
    end

    // data_ready already 1 (0x00 unread); read lands on the LOAD cycle.
    send_frame(8'h56, 1'b1, ^8'h56, 1'b1);
    idle(2);
    check_all("read_at_load", 8'h56, 1'b1, 1'b0, 1'b0, 1'b0);

    // Three low cycles: rejected at the mid-start sample.
    serial_in = 1'b0;
    idle(3);
    serial_in = 1'b1;
    idle(20);
    check_all("glitch", 8'h56, 1'b1, 1'b0, 1'b0, 1'b0);

    pulse_read();
    pulse_read();
    check_all("read_when_empty", 8'h56, 1'b0, 1'b0, 1'b0, 1'b0);

    idle(40);
    check_all("idle_line", 8'h56, 1'b0, 1'b0, 1'b0, 1'b0);

    // Exact data_ready rise; fall_cyc is the cycle before the first edge
    // that samples the low line, hence the +1.
    send_frame(8'h3A, 1'b1, ^8'h3A, 1'b0);
    idle(2);
    chk("latency", rise_cyc - fall_cyc, LAT + 1);
    check_all("latency_word", 8'h3A, 1'b1, 1'b0, 1'b0, 1'b0);
    pulse_read();

    send_frame(8'h77, 1'b1, ^8'h77, 1'b0);
    idle(2);
    check_all("pre_abort", 8'h77, 1'b1, 1'b0, 1'b0, 1'b0);

    // Partial frame 0xC3, reset halfway through data bit 4.
    drive_bit(1'b0);
    drive_bit(1'b1); drive_bit(1'b1); drive_bit(1'b0); drive_bit(1'b0);
    serial_in = 1'b0;
    idle(C/2);
    n_rst     = 1'b0;
    serial_in = 1'b1;
    #1;
    check_all("mid_reset", 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2);
    n_rst = 1'b1;
    idle(5);
    check_all("mid_reset_rel", 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h5A, 1'b1, ^8'h5A, 1'b0);
    idle(2);
    check_all("after_reset", 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0);
    pulse_read();

`ifdef SERIAL_RX_PARITY_EN
    // 0x81 is a palindrome, so time order is the same LSB- or MSB-first.
    send_frame(8'h81, 1'b1, 1'b1, 1'b0);
    idle(2);
    check_all("parity_bad", 8'h81, 1'b1, 1'b0, 1'b0, 1'b1);
    pulse_read();
    send_frame(8'h81, 1'b1, 1'b0, 1'b0);
    idle(2);
    check_all("parity_good", 8'h81, 1'b1, 1'b0, 1'b0, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/serial_rx_sr_ctrl.md
Name: serial_rx_sr_ctrl

Overview:
- Receive-side counterpart to the team's parallel-to-serial transmit shift register.
- Recovers one frame at a time from an idle-high serial line: start bit (0), NUM_BITS data bits, optional parity bit, stop bit (1).
- Timing comes from a bit-period counter; bits are collected in an internal serial-to-parallel shift register.
- Presents the word to the consumer with a ready/read handshake plus error flags. Sits between the pad and packet-level logic.

Parameters:
- NUM_BITS, 8: data bits per frame, 2..16.
- SHIFT_MSB, 1: 1 = first received data bit lands in rx_data[NUM_BITS-1], matching an MSB-first transmitter. 0 = first bit lands in rx_data[0].
- CLKS_PER_BIT, 10: clock cycles per serial bit period. Even, ≥4.

Ports:
- clk  input  1  system clock, all logic rising-edge.
- n_rst  input  1  asynchronous, active-low reset.
- serial_in  input  1  raw serial line, idle high, asynchronous to clk.
- data_read  input  1  consumer pulse: rx_data has been taken.
- rx_data  output  NUM_BITS  last good received word.
- data_ready  output  1  rx_data holds an unread word.
- framing_error  output  1  last frame had stop bit = 0.
- overrun_error  output  1  a word was overwritten before it was read.
- parity_error  output  1  parity mismatch on last frame. Tied 0 when the optional feature is absent.

Behaviour:
- **Reset:** asynchronous, active low.
  - rx_data = all 1s; data_ready, framing_error, overrun_error and parity_error = 0.
  - Synchronizer flops = 1; FSM = IDLE; bit counter = 0; shift register = all 1s.
- **Input synchronizer:** serial_in passes through two flops. All decisions use the second flop output (s_in) plus one previous-value flop for edge detect.
- **FSM states:** IDLE, START, DATA, PARITY (feature only), STOP, LOAD.
- **IDLE:** falling edge (prev = 1, s_in = 0) → START. The timer is cleared and framing_error and parity_error are cleared.
- **START:** wait CLKS_PER_BIT/2 cycles, then sample s_in at mid-bit.
  - s_in = 1: false start → IDLE, no flag change.
  - s_in = 0: → DATA, timer cleared.
- **DATA:** sample s_in every CLKS_PER_BIT cycles and shift it into the register.
  - SHIFT_MSB = 1: shift toward the MSB, new bit enters bit 0.
  - SHIFT_MSB = 0: shift toward the LSB, new bit enters bit NUM_BITS-1.
  - After NUM_BITS samples → PARITY if the feature is present, else STOP.
- **STOP:** sample after CLKS_PER_BIT cycles.
  - Sample = 1: → LOAD.
  - Sample = 0: framing_error set, rx_data and data_ready untouched, → IDLE. A new edge needs the line to return high first; the edge detect enforces this.
- **LOAD:** one cycle, then → IDLE.
  - rx_data ← shift register; data_ready ← 1.
  - If data_ready was already 1 and data_read is not asserted in this cycle: overrun_error ← 1 and rx_data is overwritten.
- **Latency:** data_ready rises on the clock after the stop-bit sample. From the falling edge at serial_in, that is 2 (sync) + CLKS_PER_BIT/2 + (NUM_BITS+1)·CLKS_PER_BIT (+CLKS_PER_BIT with parity) + 1 cycles.
- **data_read:** clears data_ready and overrun_error on the next edge.
  - data_read in the same cycle as LOAD: the LOAD wins. data_ready stays 1 with the new word, no overrun.
  - data_read while data_ready = 0: no effect.
- **Timer:** counts 0..CLKS_PER_BIT-1 and wraps; a sample fires at the terminal count. It is reset on every state entry.
- **Reset mid-frame:** immediate return to the reset values. A partially received word is discarded.
- **Idle state:** no outputs change while the line stays high.

Optional Feature:
- Macro: SERIAL_RX_PARITY_EN.
- **Defined:**
  - An even-parity bit follows the data bits, sampled in the PARITY state.
  - XOR over data plus parity ≠ 0 → parity_error = 1, and LOAD still occurs (word delivered, flagged).
  - parity_error is cleared at the next start detection.
- **Undefined:** no PARITY state, frame is start + data + stop, parity_error is constant 0.

Test Plan:
- **Good frame:** NUM_BITS = 8, SHIFT_MSB = 1, CLKS_PER_BIT = 10; send 0xA5 MSB-first with stop = 1 → rx_data = 0xA5, data_ready = 1, framing_error = 0, all other flags 0. Assert data_read → data_ready = 0 next cycle.
- **Glitch rejection:** serial_in low for 3 cycles then high → FSM returns to IDLE; rx_data, data_ready and flags unchanged.
- **Bad stop bit:** send 0x3C with stop bit = 0 → framing_error = 1, data_ready = 0, rx_data keeps its prior value. The next good frame 0x11 → framing_error cleared, rx_data = 0x11.
- **Overrun:** send 0x12 then 0x34 with no data_read → rx_data = 0x34, overrun_error = 1, data_ready = 1. data_read → both clear. Repeat with data_read coincident with the second LOAD → overrun_error stays 0.
- **Reset mid-frame:** pulse n_rst low during data bit 4 → outputs at reset values. A following frame 0x5A is received correctly.
- **Parity and bit order:** with SERIAL_RX_PARITY_EN and SHIFT_MSB = 0, send 0x81 LSB-first with parity bit = 1 → parity_error = 1, rx_data = 0x81, data_ready = 1. With parity bit = 0 → parity_error = 0.
